load_store_unit: RTL and testbench

Initiator side of the data-memory interface: it turns processor load/store requests (RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW, byte addressed) into word-addressed read/write cycles on the data memory.
- The data memory has no byte enables, so SB and SH are done as read-modify-write.
- Loads are lane-extracted and sign- or zero-extended.
- The block sits between the execute/memory stage and the data memory, and stalls the pipeline through `busy`.

---
 rtl/load_store_unit.sv | 159 +++++++++++++++
 tb/tb_load_store_unit.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Purpose : data-memory initiator turning RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW into word read/write cycles.
// Latency : loads done at cycle 3, SW at cycle 2, SB/SH (read-modify-write) at cycle 4, rejected requests at cycle 1.
// Backpressure: busy is high outside IDLE; start is ignored while busy, so the pipeline must hold the request.
//
// Ports:
//   clk, rstN                  clock, asynchronous active-low reset
//   start/is_store/funct3      request strobe, direction and RISC-V width code (sampled in IDLE)
//   byte_addr, store_data      byte address and store source (sampled with start)
//   load_data                  extended load result, held until the next load completes
//   busy, done, misaligned     stall, one-cycle completion pulse, one-cycle error pulse (with done)
//   mem_read_En/mem_write_En   memory strobes, never high together
//   mem_address, mem_data_in   word address and write data to memory
//   mem_data_out               registered memory read data, valid the cycle after mem_read_En
module load_store_unit #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 30
) (
    input  logic                     clk,
    input  logic                     rstN,
    input  logic                     start,
    input  logic                     is_store,
    input  logic [2:0]               funct3,
    input  logic [ADDRESS_WIDTH+1:0] byte_addr,
    input  logic [DATA_WIDTH-1:0]    store_data,
    output logic [DATA_WIDTH-1:0]    load_data,
    output logic                     busy,
    output logic                     done,
    output logic                     misaligned,
    output logic                     mem_read_En,
    output logic                     mem_write_En,
    output logic [ADDRESS_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0]    mem_data_in,
    input  logic [DATA_WIDTH-1:0]    mem_data_out
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RD_REQ  = 2'd1;
    localparam logic [1:0] RD_DATA = 2'd2;
    localparam logic [1:0] WR      = 2'd3;

    logic [1:0]               state;
    logic                     lat_store;
    logic [2:0]               lat_f3;
    logic [ADDRESS_WIDTH+1:0] lat_addr;
    // Holds store_data from start; for SB/SH it is overwritten with the merged word in RD_DATA,
    // so in WR it is always the word to be written.
    logic [DATA_WIDTH-1:0]    wdata;

    logic                     width_ok;
    logic                     addr_bad;
    logic                     req_bad;
    logic [7:0]               byte_sel;
    logic [15:0]              half_sel;
    logic [DATA_WIDTH-1:0]    load_ext;
    logic [DATA_WIDTH-1:0]    merged;

    // Request classification on the live inputs, used only when start is taken in IDLE.
    always_comb begin
        width_ok = 1'b0;
        if (is_store) begin
            width_ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
        end else begin
            width_ok = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
        end
        addr_bad = 1'b0;
        case (funct3[1:0])
            2'b01:   addr_bad = byte_addr[0];
            2'b10:   addr_bad = (byte_addr[1:0] != 2'b00);
            default: addr_bad = 1'b0;
        endcase
        req_bad = !width_ok || addr_bad;
    end

    // Little-endian lane extraction and extension of the returned word.
    always_comb begin
        byte_sel = mem_data_out[{lat_addr[1:0], 3'b000} +: 8];
        half_sel = mem_data_out[{lat_addr[1], 4'b0000} +: 16];
        case (lat_f3)
            3'b000:  load_ext = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
            3'b001:  load_ext = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
            3'b100:  load_ext = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
            3'b101:  load_ext = {{(DATA_WIDTH-16){1'b0}}, half_sel};
            default: load_ext = mem_data_out;
        endcase
    end

    // Sub-word store merge: the addressed lane takes the new data, other lanes keep memory contents.
    always_comb begin
        merged = mem_data_out;
        case (lat_f3[1:0])
            2'b00:   merged[{lat_addr[1:0], 3'b000} +: 8] = wdata[7:0];
            2'b01:   merged[{lat_addr[1], 4'b0000} +: 16] = wdata[15:0];
            default: merged = mem_data_out;
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state      <= IDLE;
            lat_store  <= 1'b0;
            lat_f3     <= 3'b000;
            lat_addr   <= '0;
            wdata      <= '0;
            load_data  <= '0;
            done       <= 1'b0;
            misaligned <= 1'b0;
        end else begin
            done       <= 1'b0;
            misaligned <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        lat_store <= is_store;
                        lat_f3    <= funct3;
                        lat_addr  <= byte_addr;
                        wdata     <= store_data;
                        if (req_bad) begin
                            // Rejected: no memory cycle, error reported next cycle.
                            done       <= 1'b1;
                            misaligned <= 1'b1;
                        end else if (is_store && (funct3 == 3'b010)) begin
                            state <= WR;
                        end else begin
                            state <= RD_REQ;
                        end
                    end
                end
                RD_REQ: begin
                    state <= RD_DATA;
                end
                RD_DATA: begin
                    if (lat_store) begin
                        wdata <= merged;
                        state <= WR;
                    end else begin
                        load_data <= load_ext;
                        done      <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Memory-side outputs decode from state, so an asynchronous reset removes them at once
    // (a reset during WR withdraws mem_write_En before the next edge).
    always_comb begin
        busy         = (state != IDLE);
        mem_read_En  = (state == RD_REQ);
        mem_write_En = (state == WR);
        mem_address  = (state != IDLE) ? lat_addr[ADDRESS_WIDTH+1:2] : '0;
        mem_data_in  = (state == WR) ? wdata : '0;
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
    localparam int DW = 32;
    localparam int AW = 30;

    logic          clk = 1'b0;
    logic          rstN;
    logic          start;
    logic          is_store;
    logic [2:0]    funct3;
    logic [AW+1:0] byte_addr;
    logic [DW-1:0] store_data;
    logic [DW-1:0] load_data;
    logic          busy, done, misaligned;
    logic          mem_read_En, mem_write_En;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_data_in;
    logic [DW-1:0] mem_data_out;

    always #5 clk = ~clk;

    load_store_unit #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
        .clk(clk), .rstN(rstN), .start(start), .is_store(is_store), .funct3(funct3),
        .byte_addr(byte_addr), .store_data(store_data), .load_data(load_data), .busy(busy),
        .done(done), .misaligned(misaligned), .mem_read_En(mem_read_En),
        .mem_write_En(mem_write_En), .mem_address(mem_address), .mem_data_in(mem_data_in),
        .mem_data_out(mem_data_out)
    );

    // Data memory model: registered read, no byte enables, plus a bench preload port.
    logic [31:0] mem [0:15];
    logic        pre_we;
    logic [3:0]  pre_addr;
    logic [31:0] pre_dat;
    always @(posedge clk) begin
        if (mem_read_En) mem_data_out <= mem[mem_address[3:0]];
        if (mem_write_En) mem[mem_address[3:0]] <= mem_data_in;
        if (pre_we) mem[pre_addr] <= pre_dat;
    end

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [31:0] ld;
        logic [8:0]  rd, wr, dn, ms;
        logic [29:0] addr;
        logic [31:0] wd;
    } exp_t;
    exp_t sb_q[$];

    // Per-request trace: bit n of each mask = signal level in cycle n.
    logic [8:0]  t_rd, t_wr, t_dn, t_ms;
    logic [29:0] t_raddr, t_waddr;
    logic [31:0] t_wd, t_ld;
    logic        t_both;

    function automatic logic [8:0] cyc(input int n);
        logic [8:0] one;
        one = 9'd1;
        return one << n;
    endfunction

    task automatic poke(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        pre_we = 1'b1; pre_addr = a; pre_dat = d;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    // Drives one request (start in cycle 0) and traces cycles 1..8; optionally drives a second
    // start in cycle 'inj'.
    task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] sd, input int inj, input logic ist,
                          input logic [2:0] if3, input logic [31:0] ia, input logic [31:0] isd);
        @(negedge clk);
        start = 1'b1; is_store = st; funct3 = f3; byte_addr = a; store_data = sd;
        t_rd = '0; t_wr = '0; t_dn = '0; t_ms = '0; t_both = 1'b0;
        t_raddr = '0; t_waddr = '0; t_wd = '0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            start = 1'b0;
            t_rd[c] = mem_read_En; t_wr[c] = mem_write_En;
            t_dn[c] = done;        t_ms[c] = misaligned;
            if (mem_read_En) t_raddr = mem_address;
            if (mem_write_En) begin t_waddr = mem_address; t_wd = mem_data_in; end
            if (mem_read_En && mem_write_En) t_both = 1'b1;
            if (c == inj) begin
                start = 1'b1; is_store = ist; funct3 = if3; byte_addr = ia; store_data = isd;
            end
        end
        t_ld = load_data;
    endtask

    task automatic test_reset;
        rstN = 1'b0;
        #12;
        n_checks++;
        if ({busy, done, misaligned, mem_read_En, mem_write_En} !== 5'b0) begin
            n_fail++; $display("FAIL reset_flags: got %b expected 00000", {busy, done, misaligned, mem_read_En, mem_write_En});
        end
        n_checks++;
        if ({load_data, mem_address, mem_data_in} !== '0) begin
            n_fail++; $display("FAIL reset_buses: load_data %h addr %h wdata %h expected all zero", load_data, mem_address, mem_data_in);
        end
        @(negedge clk);
        rstN = 1'b1;
    endtask

    task automatic test_loads;
        logic [2:0]  f3 [6]  = '{3'b010, 3'b000, 3'b100, 3'b001, 3'b101, 3'b000};
        logic [31:0] ad [6]  = '{32'h10, 32'h13, 32'h13, 32'h12, 32'h10, 32'h10};
        logic [31:0] ex [6]  = '{32'h8081F2F3, 32'hFFFFFF80, 32'h00000080, 32'hFFFF8081, 32'h0000F2F3, 32'hFFFFFFF3};
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            e = '{ld: ex[i], rd: cyc(1), wr: 9'd0, dn: cyc(3), ms: 9'd0, addr: 30'd4, wd: 32'd0};
            sb_q.push_back(e);
            do_req(1'b0, f3[i], ad[i], 32'hFFFF_FFFF, 0, 1'b0, 3'b0, 32'd0, 32'd0);
            e = sb_q.pop_front();
            n_checks++;
            if ({t_rd, t_wr, t_dn, t_ms} !== {e.rd, e.wr, e.dn, e.ms}) begin
                n_fail++; $display("FAIL load%0d_timing: rd/wr/done/mis %h %h %h %h expected %h %h %h %h", i, t_rd, t_wr, t_dn, t_ms, e.rd, e.wr, e.dn, e.ms);
            end
            n_checks++;
            if (t_raddr !== e.addr) begin
                n_fail++; $display("FAIL load%0d_addr: got %h expected %h", i, t_raddr, e.addr);
            end
            n_checks++;
            if (t_ld !== e.ld) begin
                n_fail++; $display("FAIL load%0d_data: got %h expected %h", i, t_ld, e.ld);
            end
        end
    endtask

    task automatic test_stores;
        logic [2:0]  f3 [3] = '{3'b000, 3'b001, 3'b010};
        logic [31:0] ad [3] = '{32'h15, 32'h16, 32'h20};
        logic [31:0] sd [3] = '{32'hDEADBEAA, 32'h0000BEEF, 32'hCAFEF00D};
        logic [31:0] ew [3] = '{32'h1122AA44, 32'hBEEFAA44, 32'hCAFEF00D};
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            if (i < 2) e = '{ld: 32'd0, rd: cyc(1), wr: cyc(3), dn: cyc(4), ms: 9'd0, addr: 30'd5, wd: ew[i]};
            else       e = '{ld: 32'd0, rd: 9'd0, wr: cyc(1), dn: cyc(2), ms: 9'd0, addr: 30'd8, wd: ew[i]};
            sb_q.push_back(e);
            do_req(1'b1, f3[i], ad[i], sd[i], 0, 1'b0, 3'b0, 32'd0, 32'd0);
            e = sb_q.pop_front();
            n_checks++;
            if ({t_rd, t_wr, t_dn, t_ms, t_both} !== {e.rd, e.wr, e.dn, e.ms, 1'b0}) begin
                n_fail++; $display("FAIL store%0d_timing: rd/wr/done/mis/both %h %h %h %h %b expected %h %h %h %h 0", i, t_rd, t_wr, t_dn, t_ms, t_both, e.rd, e.wr, e.dn, e.ms);
            end
            n_checks++;
            if ({t_waddr, t_wd} !== {e.addr, e.wd}) begin
                n_fail++; $display("FAIL store%0d_write: addr %h data %h expected %h %h", i, t_waddr, t_wd, e.addr, e.wd);
            end
            n_checks++;
            if (mem[e.addr[3:0]] !== e.wd) begin
                n_fail++; $display("FAIL store%0d_mem: got %h expected %h", i, mem[e.addr[3:0]], e.wd);
            end
        end
    endtask

    task automatic test_back_to_back;
        exp_t e;
        // SW then LW started in the SW done cycle (cycle 2): LW reads in 3, completes in 5.
        e = '{ld: 32'h12345678, rd: cyc(3), wr: cyc(1), dn: cyc(2) | cyc(5), ms: 9'd0, addr: 30'd9, wd: 32'h12345678};
        sb_q.push_back(e);
        do_req(1'b1, 3'b010, 32'h24, 32'h12345678, 2, 1'b0, 3'b010, 32'h24, 32'd0);
        e = sb_q.pop_front();
        n_checks++;
        if ({t_rd, t_wr, t_dn, t_ms} !== {e.rd, e.wr, e.dn, e.ms}) begin
            n_fail++; $display("FAIL b2b_timing: rd/wr/done/mis %h %h %h %h expected %h %h %h %h", t_rd, t_wr, t_dn, t_ms, e.rd, e.wr, e.dn, e.ms);
        end
        n_checks++;
        if ({t_raddr, t_ld} !== {e.addr, e.ld}) begin
            n_fail++; $display("FAIL b2b_load: addr %h data %h expected %h %h", t_raddr, t_ld, e.addr, e.ld);
        end
    endtask

    task automatic test_busy_ignore;
        exp_t e;
        logic [31:0] old9;
        old9 = mem[9];
        // A store started in cycle 1 of an LW must be dropped.
        e = '{ld: 32'h8081F2F3, rd: cyc(1), wr: 9'd0, dn: cyc(3), ms: 9'd0, addr: 30'd4, wd: 32'd0};
        sb_q.push_back(e);
        do_req(1'b0, 3'b010, 32'h10, 32'd0, 1, 1'b1, 3'b010, 32'h24, 32'h55555555);
        e = sb_q.pop_front();
        n_checks++;
        if ({t_rd, t_wr, t_dn, t_ms} !== {e.rd, e.wr, e.dn, e.ms}) begin
            n_fail++; $display("FAIL busy_ignore_timing: rd/wr/done/mis %h %h %h %h expected %h %h %h %h", t_rd, t_wr, t_dn, t_ms, e.rd, e.wr, e.dn, e.ms);
        end
        n_checks++;
        if ({t_ld, mem[9]} !== {e.ld, old9}) begin
            n_fail++; $display("FAIL busy_ignore_data: load %h mem9 %h expected %h %h", t_ld, mem[9], e.ld, old9);
        end
    endtask

    task automatic test_errors;
        logic        st [3] = '{1'b0, 1'b1, 1'b0};
        logic [2:0]  f3 [3] = '{3'b010, 3'b001, 3'b011};
        logic [31:0] ad [3] = '{32'h12, 32'h11, 32'h10};
        logic [31:0] old4, prev_ld;
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            old4 = mem[4];
            prev_ld = load_data;
            e = '{ld: prev_ld, rd: 9'd0, wr: 9'd0, dn: cyc(1), ms: cyc(1), addr: 30'd4, wd: old4};
            sb_q.push_back(e);
            do_req(st[i], f3[i], ad[i], 32'hA5A5A5A5, 0, 1'b0, 3'b0, 32'd0, 32'd0);
            e = sb_q.pop_front();
            n_checks++;
            if ({t_rd, t_wr, t_dn, t_ms} !== {e.rd, e.wr, e.dn, e.ms}) begin
                n_fail++; $display("FAIL err%0d_timing: rd/wr/done/mis %h %h %h %h expected %h %h %h %h", i, t_rd, t_wr, t_dn, t_ms, e.rd, e.wr, e.dn, e.ms);
            end
            n_checks++;
            if ({mem[4], t_ld} !== {e.wd, e.ld}) begin
                n_fail++; $display("FAIL err%0d_state: mem4 %h load %h expected %h %h", i, mem[4], t_ld, e.wd, e.ld);
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] old5;
        logic        saw_wr;
        exp_t e;
        old5 = mem[5];
        saw_wr = 1'b0;
        @(negedge clk);
        start = 1'b1; is_store = 1'b1; funct3 = 3'b000; byte_addr = 32'h14; store_data = 32'h77;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL rst_mid_busy_before: got %b expected 1", busy);
        end
        rstN = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, mem_read_En, mem_write_En, load_data, mem_address, mem_data_in} !== '0) begin
            n_fail++; $display("FAIL rst_mid_outputs: busy %b wr %b load %h addr %h expected zeros", busy, mem_write_En, load_data, mem_address);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            rstN = 1'b1;
            if (mem_write_En) saw_wr = 1'b1;
        end
        n_checks++;
        if ({saw_wr, mem[5]} !== {1'b0, old5}) begin
            n_fail++; $display("FAIL rst_mid_no_write: write_seen %b mem5 %h expected 0 %h", saw_wr, mem[5], old5);
        end
        e = '{ld: old5, rd: cyc(1), wr: 9'd0, dn: cyc(3), ms: 9'd0, addr: 30'd5, wd: 32'd0};
        sb_q.push_back(e);
        do_req(1'b0, 3'b010, 32'h14, 32'd0, 0, 1'b0, 3'b0, 32'd0, 32'd0);
        e = sb_q.pop_front();
        n_checks++;
        if ({t_rd, t_dn, t_ld} !== {e.rd, e.dn, e.ld}) begin
            n_fail++; $display("FAIL rst_mid_recover: rd %h done %h load %h expected %h %h %h", t_rd, t_dn, t_ld, e.rd, e.dn, e.ld);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within bound");
        $fatal(1, "timeout");
    end

    initial begin
        start = 1'b0; is_store = 1'b0; funct3 = 3'b0; byte_addr = '0; store_data = '0;
        pre_we = 1'b0; pre_addr = '0; pre_dat = '0;
        test_reset;
        poke(4'd4, 32'h8081F2F3);
        poke(4'd5, 32'h11223344);
        poke(4'd8, 32'h00000000);
        poke(4'd9, 32'h00000000);
        test_loads;
        test_stores;
        test_back_to_back;
        test_busy_ignore;
        test_errors;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
